// File: rtl/irq_pending_latch_pkg.sv
// Shared definitions for the interrupt pending latch: widths, FSM states and the
// index-to-onehot decode used to clear an accepted pending bit.
package irq_pending_latch_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  function automatic logic [7:0] onehot3to8(input logic [2:0] idx);
    logic [7:0] v;
    v      = 8'h00;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/irq_edge_capture.sv
// Request synchronizer, previous-sample register and rising-edge detect.
// Define IRQ_SYNC2_EN to add a second synchronizer stage for truly async sources.
module irq_edge_capture #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] rise
);

`ifdef IRQ_SYNC2_EN
  localparam int DEPTH = 3;
  logic [W-1:0] m_reg;
  logic [W-1:0] s1_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_reg <= '0;
    else        m_reg <= din;
  end
  assign s1_d = m_reg;
`else
  localparam int DEPTH = 2;
  logic [W-1:0] s1_d;
  assign s1_d = din;
`endif

  logic [W-1:0]     s1_reg;
  logic [W-1:0]     prev_reg;
  // Fill tracker: edges are only reported once prev_reg holds a real sample, so a
  // line already high when reset releases does not look like a fresh rise.
  logic [DEPTH-1:0] fill_reg;
  logic             armed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_reg   <= '0;
      prev_reg <= '0;
      fill_reg <= '0;
    end else begin
      s1_reg   <= s1_d;
      prev_reg <= s1_reg;
      fill_reg <= {fill_reg[DEPTH-2:0], 1'b1};
    end
  end

  assign armed = fill_reg[DEPTH-1];

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_rise
      assign rise[gi] = s1_reg[gi] & ~prev_reg[gi] & armed;
    end
  endgenerate

endmodule

// File: rtl/irq_pending_latch.sv
// Sticky pending register with mask, feeding an external 8:3 encoder and presenting
// the winning index over valid/ready. Optional macro: IRQ_SYNC2_EN (two-flop capture).
import irq_pending_latch_pkg::*;

module irq_pending_latch #(
  parameter int               N_REQ    = 8,
  parameter logic [N_REQ-1:0] MASK_RST = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_in,
  input  logic             mask_we,
  input  logic [N_REQ-1:0] mask_wdata,
  input  logic [IDX_W-1:0] enc_idx,
  output logic [N_REQ-1:0] pend_masked,
  output logic [N_REQ-1:0] pend_raw,
  output logic             irq_valid,
  output logic [IDX_W-1:0] irq_id,
  input  logic             irq_ready
);

  generate
    if (N_REQ != 8) begin : g_width_check
      $error("irq_pending_latch: only N_REQ = 8 is supported");
    end
  endgenerate

  logic [N_REQ-1:0] rise;
  logic [N_REQ-1:0] pending_reg, pending_next;
  logic [N_REQ-1:0] mask_reg;
  logic [N_REQ-1:0] clr_vec;
  state_t           state_reg, state_next;
  logic             irq_valid_reg, irq_valid_next;
  logic [IDX_W-1:0] irq_id_reg, irq_id_next;

  irq_edge_capture #(.W(N_REQ)) u_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (req_in),
    .rise  (rise)
  );

  // A rise landing on the same edge as its own clear must survive.
  assign pending_next = (pending_reg & ~clr_vec) | rise;
  assign pend_masked  = pending_reg & ~mask_reg;
  assign pend_raw     = pending_reg;
  assign irq_valid    = irq_valid_reg;
  assign irq_id       = irq_id_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_reg   <= '0;
      mask_reg      <= MASK_RST;
      state_reg     <= IDLE;
      irq_valid_reg <= 1'b0;
      irq_id_reg    <= '0;
    end else begin
      pending_reg   <= pending_next;
      if (mask_we) mask_reg <= mask_wdata;
      state_reg     <= state_next;
      irq_valid_reg <= irq_valid_next;
      irq_id_reg    <= irq_id_next;
    end
  end

  // enc_idx is only sampled when pend_masked is non-zero.
  always_comb begin
    state_next     = state_reg;
    irq_valid_next = irq_valid_reg;
    irq_id_next    = irq_id_reg;
    clr_vec        = '0;
    case (state_reg)
      IDLE: begin
        if (|pend_masked) begin
          irq_id_next    = enc_idx;
          irq_valid_next = 1'b1;
          state_next     = PRESENT;
        end
      end
      PRESENT: begin
        if (irq_ready) begin
          clr_vec        = onehot3to8(irq_id_reg);
          irq_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
    endcase
  end

endmodule
